// File: rtl/nibble_pixel_unpacker_pkg.sv
// rtl/nibble_pixel_unpacker_pkg.sv - shared types and constants for the nibble pixel unpacker
package nibble_pixel_unpacker_pkg;

    localparam int NIBBLE_W = 4;
    localparam int PIX_W    = 8;

    localparam int DEFAULT_H_PIXELS = 640;
    localparam int DEFAULT_V_LINES  = 480;

    // EMPTY: nothing held; HI/LO: which nibble of the held byte is on out_pixel
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } unpack_state_t;

endpackage

// File: rtl/pixel_pos_counter.sv
// rtl/pixel_pos_counter.sv - column/row position tracker with end-of-line/frame decode
module pixel_pos_counter
    import nibble_pixel_unpacker_pkg::*;
#(
    parameter int H_PIXELS = DEFAULT_H_PIXELS,
    parameter int V_LINES  = DEFAULT_V_LINES,
    parameter int CNT_W    = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    output logic eol,
    output logic eof
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_PIXELS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_LINES - 1);

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row <= '0;
                end else begin
                    row <= row + CNT_W'(1);
                end
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    assign eol = (col == COL_LAST);
    assign eof = eol && (row == ROW_LAST);

endmodule

// File: rtl/nibble_pixel_unpacker.sv
// rtl/nibble_pixel_unpacker.sv - splits packed bytes into two expanded 8-bit pixels
// EXPAND_REPLICATE_EN selects nibble replication instead of zero-fill expansion.
module nibble_pixel_unpacker
    import nibble_pixel_unpacker_pkg::*;
#(
    parameter int H_PIXELS = DEFAULT_H_PIXELS,
    parameter int V_LINES  = DEFAULT_V_LINES,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eol,
    output logic             out_eof
);

    unpack_state_t        state;
    logic [PIX_W-1:0]     held;
    logic [NIBBLE_W-1:0]  nib;
    logic                 in_fire;
    logic                 out_fire;

    // A new byte may land in the same cycle the low nibble leaves
    assign in_ready  = (state == ST_EMPTY) || ((state == ST_LO) && out_ready);
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            held  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        held  <= in_data;
                        state <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (out_fire) begin
                        state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (out_fire) begin
                        if (in_fire) begin
                            held  <= in_data;
                            state <= ST_HI;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign nib = (state == ST_LO) ? held[NIBBLE_W-1:0] : held[PIX_W-1:NIBBLE_W];

`ifdef EXPAND_REPLICATE_EN
    assign out_pixel = {nib, nib};
`else
    assign out_pixel = {nib, {NIBBLE_W{1'b0}}};
`endif

    pixel_pos_counter #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES),
        .CNT_W    (CNT_W)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .advance (out_fire),
        .eol     (out_eol),
        .eof     (out_eof)
    );

endmodule

// File: tb/tb_nibble_pixel_unpacker.sv
// tb/tb_nibble_pixel_unpacker.sv - scoreboard bench for nibble_pixel_unpacker on a 4x2 frame
module tb_nibble_pixel_unpacker;

    localparam int H = 4;
    localparam int V = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_eol;
    logic       out_eof;

    typedef struct packed {
        logic [7:0] pix;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   push_cnt = 0;
    int   popped   = 0;

    nibble_pixel_unpacker #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .CNT_W    (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] expand(input logic [3:0] n);
`ifdef EXPAND_REPLICATE_EN
        return {n, n};
`else
        return {n, 4'h0};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_pixel(input logic [3:0] n);
        exp_t e;
        int   pos;
        pos   = push_cnt % (H * V);
        e.pix = expand(n);
        e.eol = ((pos % H) == H - 1);
        e.eof = e.eol && ((pos / H) == V - 1);
        sb.push_back(e);
        push_cnt++;
    endtask

    // Called just after a falling edge with inputs already driven; commits one clock.
    task automatic tick(output bit acc);
        bit   of;
        bit   inf;
        exp_t e;
        #1;
        of  = out_valid && out_ready && !rst;
        inf = in_valid && in_ready && !rst;
        if (of) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_pixel", 32'(out_pixel), 32'(e.pix));
                check("sb_eol", 32'(out_eol), 32'(e.eol));
                check("sb_eof", 32'(out_eof), 32'(e.eof));
            end
            popped++;
        end
        if (inf) begin
            push_pixel(in_data[7:4]);
            push_pixel(in_data[3:0]);
        end
        acc = inf;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bit acc;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick(acc);
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        push_cnt = 0;
    endtask

    initial begin
        bit   acc;
        int   idx;
        int   n_eol;
        int   n_eof;
        int   cycles;
        logic [7:0] stream [3];
        stream[0] = 8'h01;
        stream[1] = 8'h23;
        stream[2] = 8'h45;

        @(negedge clk);
        do_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_pixel", 32'(out_pixel), 32'h00);
        check("rst_out_eol", 32'(out_eol), 32'd0);
        check("rst_out_eof", 32'(out_eof), 32'd0);

        // 0xA5 with out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        tick(acc);
        check("t1_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        #1;
        check("t1_valid_hi", 32'(out_valid), 32'd1);
`ifdef EXPAND_REPLICATE_EN
        check("t1_pix_hi", 32'(out_pixel), 32'hAA);
`else
        check("t1_pix_hi", 32'(out_pixel), 32'hA0);
`endif
        tick(acc);
        #1;
        check("t1_valid_lo", 32'(out_valid), 32'd1);
`ifdef EXPAND_REPLICATE_EN
        check("t1_pix_lo", 32'(out_pixel), 32'h55);
`else
        check("t1_pix_lo", 32'(out_pixel), 32'h50);
`endif
        tick(acc);
        #1;
        check("t1_drained", 32'(out_valid), 32'd0);

        // Back-to-back bytes: in_ready alternates, no output bubbles
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? stream[idx] : 8'h00;
            #1;
            check("t2_in_ready", 32'(in_ready), 32'((i % 2) == 0));
            check("t2_out_valid", 32'(out_valid), 32'(i > 0));
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("t2_bytes_taken", 32'(idx), 32'd3);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure while the low nibble of 0xC7 is pending
        in_valid = 1'b1;
        in_data  = 8'hC7;
        tick(acc);
        in_valid = 1'b0;
        tick(acc);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h99;
            #1;
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_pixel", 32'(out_pixel), 32'(expand(4'h7)));
            check("t3_hold_in_ready", 32'(in_ready), 32'd0);
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(acc);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // One full 4x2 frame plus the first pixel of the next frame
        do_reset();
        out_ready = 1'b1;
        n_eol = 0;
        n_eof = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0) && (i < 10);
            in_data  = 8'(8'h10 * i + 8'h08);
            #1;
            if (out_valid && out_eol) n_eol++;
            if (out_valid && out_eof) n_eof++;
            tick(acc);
        end
        in_valid = 1'b0;
        check("t4_eol_count", 32'(n_eol), 32'd2);
        check("t4_eof_count", 32'(n_eof), 32'd1);
        tick(acc);
        #1;
        check("t4_idle", 32'(out_valid), 32'd0);

        // Reset while in LO
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick(acc);
        in_valid = 1'b0;
        tick(acc);
        #1;
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        do_reset();
        #1;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_out_pixel", 32'(out_pixel), 32'h00);
        in_valid = 1'b1;
        in_data  = 8'h12;
        tick(acc);
        check("t5_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        #1;
        check("t5_first_eol", 32'(out_eol), 32'd0);
        check("t5_first_pixel", 32'(out_pixel), 32'(expand(4'h1)));
        tick(acc);
        tick(acc);

        // Random handshakes over 10k pixels
        popped = 0;
        cycles = 0;
        while (popped < 10000 && cycles < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick(acc);
            cycles++;
        end
        check("t6_budget", 32'(popped >= 10000), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(acc);
        end
        #1;
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_pixel_unpacker.md
Name: nibble_pixel_unpacker

Overview:
Read-side counterpart of the 8-bit dithering quantizer. The quantizer keeps only the upper nibble of each colour, so frame memory stores two 4-bit pixels per byte. This block takes packed bytes from the frame-memory read path and emits one expanded 8-bit colour per pixel toward the VGA pixel pipeline. It also tracks line and frame position for downstream sync alignment.

Parameters:
H_PIXELS, 640, pixels per line; must be even (two pixels per byte).
V_LINES, 480, lines per frame.
CNT_W, 10, width of column and row counters; must satisfy 2^CNT_W >= max(H_PIXELS, V_LINES).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_data  input  8  packed byte; [7:4] = pixel n, [3:0] = pixel n+1
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts in_data this cycle
out_pixel  output  8  expanded colour value
out_valid  output  1  out_pixel is valid
out_ready  input  1  downstream accepts out_pixel this cycle
out_eol  output  1  out_pixel is the last pixel of a line (qualified by out_valid)
out_eof  output  1  out_pixel is the last pixel of a frame (qualified by out_valid)

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high. All state updates on posedge clk.
- Transfers: an input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- States:
  - EMPTY: no byte held.
  - HI: byte held, upper nibble presented.
  - LO: lower nibble presented.
- Transitions:
  - EMPTY: on input transfer, latch in_data and go to HI.
  - HI: on output transfer, go to LO.
  - LO: on output transfer, go to HI if an input transfer occurs in the same cycle (new byte latched); otherwise go to EMPTY.
- in_ready = (state==EMPTY) || (state==LO && out_ready). It is combinational from state and out_ready, with no dependence on in_valid. Sustained throughput is one pixel per cycle, with no bubble between bytes.
- out_valid = (state != EMPTY).
- out_pixel = expand(held[7:4]) in HI and expand(held[3:0]) in LO. Expansion rule is given under Optional Feature.
- Latency: a byte accepted at cycle t gives its upper pixel with out_valid high at t+1.
- Backpressure: while out_valid && !out_ready, out_pixel, out_eol, out_eof and state hold stable. The held byte is never overwritten while a pixel from it is pending.
- Position counters:
  - col and row advance only on output transfers.
  - col wraps from H_PIXELS-1 to 0 and increments row at the wrap.
  - row wraps from V_LINES-1 to 0.
- Flags:
  - out_eol = (col == H_PIXELS-1).
  - out_eof = out_eol && (row == V_LINES-1).
  - Both are combinational from the counters.
- Reset values: state EMPTY, held byte 0x00, col 0, row 0. Resulting outputs: out_valid 0, in_ready 1, out_pixel 0x00, out_eol 0, out_eof 0.
- Reset mid-operation: any pending pixel or byte is discarded and counters return to 0. An in_valid asserted during rst is not accepted.
- Input arriving in HI is not accepted (in_ready=0). Data has no effect when in_valid=0.

Optional Feature:
Macro EXPAND_REPLICATE_EN.
- Defined: expand(n) = {n, n}, so 0xF gives 0xFF and 0x0 gives 0x00 (full-scale expansion).
- Undefined: expand(n) = {n, 4'h0}, bit-exact with the quantizer output, so 0xF gives 0xF0.
- Handshake and counters are identical in both builds.

Decomposition:
- Shared package:
  - State enum typedef (EMPTY/HI/LO).
  - Default H_PIXELS/V_LINES constants.
  - NIBBLE_W=4 and PIX_W=8 constants, also used by the dithering block.
- One natural sub-module, pixel_pos_counter: col/row counters with eol/eof decode, reusable by the VGA timing side.
- Nibble expansion stays inline.

Test Plan:
1. Reset, then in_data=0xA5 with out_ready=1 held high -> out_pixel 0xAA then 0x55 (replicate build), or 0xA0 then 0x50 (zero-fill build). Both appear on consecutive cycles, starting one cycle after acceptance.
2. Stream bytes 0x01,0x23,0x45 back-to-back with out_ready=1 -> in_ready high every other cycle. Pixels 0,1,2,3,4,5 (expanded) are output on six consecutive cycles with no gap.
3. After output of pixel 0xC from byte 0xC7, hold out_ready=0 for 5 cycles -> out_pixel stays at expand(0x7), in_ready stays 0, and no pixel is lost.
4. Full frame of H_PIXELS=4, V_LINES=2 (4 bytes) -> out_eol on pixels 3 and 7, out_eof only on pixel 7. The next pixel shows col=0, row=0.
5. Assert rst while in state LO -> next cycle out_valid=0, in_ready=1, counters 0. A new byte's first pixel shows out_eol=0.
6. Random in_valid and out_ready over 10k pixels against a reference model -> pixel order and values match, and there are no duplicated or dropped pixels.
